// File: rtl/ama_riscv_reg_file_pkg.sv
// Shared types and defaults for the multi-read-port register file.
// Clear FSM encoding and default geometry live here.
package ama_riscv_reg_file_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;
  localparam int MAX_RD     = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/ama_riscv_reg_file_if.sv
// Decode-side bundle of the register file: write port,
// packed read ports, clear request and status.
interface ama_riscv_reg_file_if
  import ama_riscv_reg_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD
);

  logic                     we;
  logic [ADDR_W-1:0]        addr_d;
  logic [DATA_W-1:0]        data_d;
  logic [NUM_RD*ADDR_W-1:0] addr_r;
  logic [NUM_RD*DATA_W-1:0] data_r;
  logic                     clear_req;
  logic                     busy;
  logic                     wr_drop;

  modport master (
    output we,
    output addr_d,
    output data_d,
    output addr_r,
    output clear_req,
    input  data_r,
    input  busy,
    input  wr_drop
  );

  modport slave (
    input  we,
    input  addr_d,
    input  data_d,
    input  addr_r,
    input  clear_req,
    output data_r,
    output busy,
    output wr_drop
  );

endinterface

// File: rtl/ama_riscv_reg_file_clr_fsm.sv
// Sequenced clear engine: sweeps one entry per cycle,
// flags busy and reports writes dropped while sweeping.
module ama_riscv_reg_file_clr_fsm
  import ama_riscv_reg_file_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_req,
  input  logic              we,
  output logic              busy,
  output logic              wr_drop,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr
);

  clr_state_e        state;
  logic [ADDR_W-1:0] ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      busy    <= 1'b0;
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= we & busy;
      unique case (state)
        ST_IDLE: begin
          if (clear_req) begin
            state <= ST_CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          // a request seen here is dropped, not queued
          ptr <= ptr + 1'b1;
          if (ptr == '1) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign clr_en   = (state == ST_CLEAR);
  assign clr_addr = ptr;

endmodule

// File: rtl/ama_riscv_reg_file_mp.sv
// Parametrised multi-read-port register file with clear engine.
// Define REG_FILE_BYPASS_EN for write-first read bypass.
module ama_riscv_reg_file_mp
  import ama_riscv_reg_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ama_riscv_reg_file_if.slave   bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              busy;
  logic              wr_drop;
  logic              clr_en;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_zero;
  logic              wr_ok;

  assign wr_zero = ZR && (bus.addr_d == '0);
  assign wr_ok   = bus.we && !busy && !wr_zero;

  ama_riscv_reg_file_clr_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_req (bus.clear_req),
    .we        (bus.we),
    .busy      (busy),
    .wr_drop   (wr_drop),
    .clr_en    (clr_en),
    .clr_addr  (clr_addr)
  );

  // clear and write never collide: writes are blocked while busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (clr_en) begin
        mem[clr_addr] <= '0;
      end else if (wr_ok) begin
        mem[bus.addr_d] <= bus.data_d;
      end
    end
  end

  logic [DATA_W-1:0] rd [NUM_RD];

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              ra_zero;
    logic              byp;
    logic [DATA_W-1:0] q;

    assign ra      = bus.addr_r[k*ADDR_W +: ADDR_W];
    assign ra_zero = ZR && (ra == '0);

`ifdef REG_FILE_BYPASS_EN
    assign byp = wr_ok && (bus.addr_d == ra);
`else
    assign byp = 1'b0;
`endif

    always_comb begin
      q = '0;
      unique case (1'b1)
        ra_zero: q = '0;
        byp:     q = bus.data_d;
        default: q = mem[ra];
      endcase
    end

    assign rd[k] = q;
  end

  logic [NUM_RD*DATA_W-1:0] rd_bus;

  always_comb begin
    rd_bus = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_bus[k*DATA_W +: DATA_W] = rd[k];
    end
  end

  assign bus.data_r  = rd_bus;
  assign bus.busy    = busy;
  assign bus.wr_drop = wr_drop;

endmodule
